// File: rtl/traffic_lamp_driver_pkg.sv
// traffic_pkg: shared types for the traffic lamp driver.
//   phase_t     - FSM phase encoding (also exported on PHASE)
//   lamp_t      - one road's lamps packed as {R,Y,G}
//   lamps_t     - both roads' lamps {hwy, cty}
//   phase_lamps - Moore decode from phase to the six lamps
package traffic_pkg;

  typedef enum logic [2:0] {
    ALL_RED    = 3'd0,
    HWY_GREEN  = 3'd1,
    HWY_YELLOW = 3'd2,
    CTY_GREEN  = 3'd3,
    CTY_YELLOW = 3'd4
  } phase_t;

  typedef logic [2:0] lamp_t;  // {R,Y,G}

  localparam lamp_t LAMP_RED = 3'b100;
  localparam lamp_t LAMP_YEL = 3'b010;
  localparam lamp_t LAMP_GRN = 3'b001;

  typedef struct packed {
    lamp_t hwy;
    lamp_t cty;
  } lamps_t;

  // Any phase not naming a road leaves that road red, so an unknown
  // encoding fails safe to all-red.
  function automatic lamps_t phase_lamps(input phase_t ph);
    lamps_t l;
    l.hwy = LAMP_RED;
    l.cty = LAMP_RED;
    case (ph)
      HWY_GREEN:  l.hwy = LAMP_GRN;
      HWY_YELLOW: l.hwy = LAMP_YEL;
      CTY_GREEN:  l.cty = LAMP_GRN;
      CTY_YELLOW: l.cty = LAMP_YEL;
      default:    ;
    endcase
    return l;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_lamp_driver_phase_timer.sv
// phase_timer: loadable down-counter measuring time spent in a phase.
//   CLK      - rising-edge clock
//   RST_N    - async active-low reset, counter returns to RST_VAL
//   load     - load load_val this edge (wins over counting)
//   load_val - N-1 for a phase of duration N
//   expired  - counter is zero; the counter holds at zero
module phase_timer #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              r_cnt <= RST_VAL;
    else if (load)           r_cnt <= load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver: turns SignalSystem's highway/country green requests
// into six lamp drives with minimum green, fixed yellow and all-red
// clearance, and flags conflicting requests.
//   CLK, RST_N           - clock, async active-low reset
//   HL, CL               - highway / country green requests (same domain)
//   HWY_R/Y/G, CTY_R/Y/G - registered lamp drives
//   FAULT                - sticky, set when HL and CL are both high
//   PHASE                - current phase encoding (phase_t)
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_CYCLES = 4,
  parameter int YELLOW_CYCLES    = 3,
  parameter int ALLRED_CYCLES    = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       HL,
  input  logic       CL,
  output logic       HWY_R,
  output logic       HWY_Y,
  output logic       HWY_G,
  output logic       CTY_R,
  output logic       CTY_Y,
  output logic       CTY_G,
  output logic       FAULT,
  output logic [2:0] PHASE
);

  localparam int TMAX = max3(MIN_GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] LD_GRN = TW'(MIN_GREEN_CYCLES - 1);
  localparam logic [TW-1:0] LD_YEL = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] LD_RED = TW'(ALLRED_CYCLES - 1);

  phase_t          r_phase;
  lamp_t           r_hwy;
  lamp_t           r_cty;
  logic            r_fault;

  phase_t          w_nxt;
  logic            w_load;
  logic [TW-1:0]   w_load_val;
  logic            w_expired;
  logic            w_req_h;
  logic            w_req_c;
  logic            w_conflict;

  // A conflicting pair requests neither road.
  assign w_conflict = HL & CL;
  assign w_req_h    = HL & ~CL;
  assign w_req_c    = CL & ~HL;

  // Timer resets to the all-red load so clearance is honoured after reset.
  phase_timer #(
    .W       (TW),
    .RST_VAL (LD_RED)
  ) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  // Next-phase selection; the timer is loaded exactly on phase entry.
  always_comb begin
    w_nxt      = r_phase;
    w_load     = 1'b0;
    w_load_val = LD_RED;
    unique case (r_phase)
      ALL_RED: begin
        if (w_expired && w_req_h) begin
          w_nxt = HWY_GREEN; w_load = 1'b1; w_load_val = LD_GRN;
        end else if (w_expired && w_req_c) begin
          w_nxt = CTY_GREEN; w_load = 1'b1; w_load_val = LD_GRN;
        end
      end
      HWY_GREEN: begin
        if (w_expired && !w_req_h) begin
          w_nxt = HWY_YELLOW; w_load = 1'b1; w_load_val = LD_YEL;
        end
      end
      HWY_YELLOW: begin
        if (w_expired) begin
          w_nxt = ALL_RED; w_load = 1'b1; w_load_val = LD_RED;
        end
      end
      CTY_GREEN: begin
        if (w_expired && !w_req_c) begin
          w_nxt = CTY_YELLOW; w_load = 1'b1; w_load_val = LD_YEL;
        end
      end
      CTY_YELLOW: begin
        if (w_expired) begin
          w_nxt = ALL_RED; w_load = 1'b1; w_load_val = LD_RED;
        end
      end
      default: begin
        w_nxt = ALL_RED; w_load = 1'b1; w_load_val = LD_RED;
      end
    endcase
  end

  // Lamps are registered from the next phase so they always equal the
  // decode of r_phase without a combinational path from HL/CL.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_phase <= ALL_RED;
      r_hwy   <= LAMP_RED;
      r_cty   <= LAMP_RED;
      r_fault <= 1'b0;
    end else begin
      r_phase        <= w_nxt;
      {r_hwy, r_cty} <= phase_lamps(w_nxt);
      if (w_conflict) r_fault <= 1'b1;
    end
  end

  assign {HWY_R, HWY_Y, HWY_G} = r_hwy;
  assign {CTY_R, CTY_Y, CTY_G} = r_cty;
  assign FAULT                 = r_fault;
  assign PHASE                 = r_phase;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Bench for traffic_lamp_driver: directed scenarios plus randomized request
// streams checked against a phase/age reference model.
module tb_traffic_lamp_driver;

  localparam int MING = 4;
  localparam int YEL  = 3;
  localparam int ARED = 2;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       HL, CL;
  logic       HWY_R, HWY_Y, HWY_G, CTY_R, CTY_Y, CTY_G, FAULT;
  logic [2:0] PHASE;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase number and how many cycles it has been shown so far.
  int m_ph, m_age;
  bit m_fault;

  traffic_lamp_driver #(
    .MIN_GREEN_CYCLES (MING),
    .YELLOW_CYCLES    (YEL),
    .ALLRED_CYCLES    (ARED)
  ) dut (
    .CLK (CLK), .RST_N (RST_N), .HL (HL), .CL (CL),
    .HWY_R (HWY_R), .HWY_Y (HWY_Y), .HWY_G (HWY_G),
    .CTY_R (CTY_R), .CTY_Y (CTY_Y), .CTY_G (CTY_G),
    .FAULT (FAULT), .PHASE (PHASE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_lamp(input int ph, input bit hwy);
    int g;
    g = hwy ? 1 : 3;
    if (ph == g)     return 3'b001;
    if (ph == g + 1) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_age = 1; m_fault = 0;
  endtask

  task automatic model_edge(input bit hl, input bit cl);
    bit rh, rc;
    int nph;
    rh  = hl & !cl;
    rc  = cl & !hl;
    if (hl && cl) m_fault = 1;
    nph = m_ph;
    case (m_ph)
      0: if (m_age >= ARED) nph = rh ? 1 : (rc ? 3 : 0);
      1: if (m_age >= MING && !rh) nph = 2;
      2: if (m_age >= YEL) nph = 0;
      3: if (m_age >= MING && !rc) nph = 4;
      4: if (m_age >= YEL) nph = 0;
      default: nph = 0;
    endcase
    if (nph != m_ph) begin m_ph = nph; m_age = 1; end
    else m_age++;
  endtask

  task automatic compare_all();
    chk("phase", PHASE, m_ph);
    chk("hwy_lamps", {HWY_R, HWY_Y, HWY_G}, exp_lamp(m_ph, 1'b1));
    chk("cty_lamps", {CTY_R, CTY_Y, CTY_G}, exp_lamp(m_ph, 1'b0));
    chk("fault", FAULT, m_fault);
  endtask

  task automatic step(input bit hl, input bit cl);
    HL = hl; CL = cl;
    @(posedge CLK);
    model_edge(hl, cl);
    #1;
    compare_all();
  endtask

  // Mid-cycle asynchronous reset pulse; lamps must react before any edge.
  task automatic async_reset(input string tag);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    chk({tag, "_hwy_r"}, HWY_R, 1);
    chk({tag, "_cty_r"}, CTY_R, 1);
    chk({tag, "_fault"}, FAULT, 0);
    chk({tag, "_phase"}, PHASE, 0);
    #2 RST_N = 1'b1;
  endtask

  // Lamp invariants every cycle: one-hot per road, at least one road red.
  always @(negedge CLK) begin
    chk("inv_hwy_onehot", $countones({HWY_R, HWY_Y, HWY_G}), 1);
    chk("inv_cty_onehot", $countones({CTY_R, CTY_Y, CTY_G}), 1);
    chk("inv_one_red", HWY_R | CTY_R, 1);
  end

  int seq_a[9]  = '{1, 1, 1, 2, 2, 2, 0, 0, 3};
  int seq_b[10] = '{3, 3, 3, 4, 4, 4, 0, 0, 0, 0};

  initial begin
    bit hl, cl;
    int hold, r;
    RST_N = 1'b0; HL = 1'b1; CL = 1'b0;
    model_reset();
    #12;
    compare_all();
    chk("rst_hwy_r", HWY_R, 1);
    chk("rst_cty_r", CTY_R, 1);
    #4 RST_N = 1'b1;

    // Release with HL: two all-red cycles, green on the 2nd edge.
    step(1, 0);
    chk("t1_not_yet_green", HWY_G, 0);
    step(1, 0);
    chk("t1_hwy_green", HWY_G, 1);
    chk("t1_cty_red", CTY_R, 1);

    // Handover after one green cycle: G x4 total, Y x3, R x2, then C:G.
    foreach (seq_a[i]) begin
      step(0, 1);
      chk("t3_seq", PHASE, seq_a[i]);
    end
    chk("t2_cty_green", CTY_G, 1);

    // No requests: country finishes min green, yellow, then idle all-red.
    foreach (seq_b[i]) begin
      step(0, 0);
      chk("t4_seq", PHASE, seq_b[i]);
    end
    chk("t4_all_red", {HWY_R, CTY_R}, 2'b11);

    // Conflict during highway green past min green.
    step(1, 0);
    chk("t5_green_latency", HWY_G, 1);
    repeat (3) step(1, 0);
    step(1, 1);
    chk("t5_fault_set", FAULT, 1);
    chk("t5_to_yellow", HWY_Y, 1);
    repeat (3) step(0, 0);
    chk("t5_all_red", PHASE, 0);
    repeat (4) step(0, 1);
    chk("t5_fault_sticky", FAULT, 1);

    // Walk back into highway yellow, then reset between edges.
    for (int i = 0; i < 40 && m_ph != 2; i++) step(m_ph == 1 ? 1'b0 : 1'b1, 1'b0);
    chk("t6_in_yellow", PHASE, 2);
    async_reset("t6");
    step(0, 1);
    chk("t6_clear_1", CTY_G, 0);
    step(0, 1);
    chk("t6_cty_green", CTY_G, 1);

    // Randomized request streams held for random durations.
    hold = 0; hl = 0; cl = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 19);
        if (r < 8)       begin hl = 1; cl = 0; end
        else if (r < 16) begin hl = 0; cl = 1; end
        else if (r < 19) begin hl = 0; cl = 0; end
        else             begin hl = 1; cl = 1; end
        hold = (r == 19) ? 1 : $urandom_range(1, 9);
      end
      hold--;
      step(hl, cl);
      if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_driver.md
Name: traffic_lamp_driver

Overview:
- Downstream stage of SignalSystem. Consumes its registered light requests HL (highway green) and CL (country green).
- Drives the six physical lamps: red/yellow/green for each road.
- Enforces minimum green time, a fixed yellow interval and an all-red clearance interval, so a road never shows green while the other road is non-red.
- Flags illegal request combinations from the controller.

Parameters:
- MIN_GREEN_CYCLES, 4: minimum cycles a road stays green once entered (≥1).
- YELLOW_CYCLES, 3: exact cycles of yellow before red (≥1).
- ALLRED_CYCLES, 2: minimum cycles of all-red clearance between greens (≥1).

Ports:
- CLK, input, 1: system clock, rising-edge.
- RST_N, input, 1: reset, asynchronous, active-low.
- HL, input, 1: highway green request from SignalSystem; same clock domain, no synchroniser.
- CL, input, 1: country green request from SignalSystem; same clock domain.
- HWY_R, HWY_Y, HWY_G, output, 1 each: highway lamps.
- CTY_R, CTY_Y, CTY_G, output, 1 each: country lamps.
- FAULT, output, 1: sticky; set when HL=CL=1 is sampled.
- PHASE, output, 3: current FSM state encoding, for debug and bench.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low (RST_N).
- Reset values:
  - State is ALL_RED; timer is loaded with ALLRED_CYCLES-1.
  - HWY_R=CTY_R=1; all Y and G outputs 0; FAULT=0; PHASE=ALL_RED.
- Outputs: Moore, decoded only from the state register. No combinational path from HL/CL to lamps.
- Invariants, every cycle:
  - Exactly one of R/Y/G is high per road.
  - At least one road shows red.
- Timer:
  - Down-counter of width $clog2(max parameter).
  - Loaded with N-1 on entry to a state of duration N; decrements each cycle while nonzero.
  - "expired" means timer==0.
  - A state therefore lasts at least N cycles.
- Request decode, per cycle:
  - reqH = HL & ~CL; reqC = CL & ~HL.
  - HL=CL=1 is a conflict: treated as reqH=reqC=0, and sets FAULT on the same edge.
- FSM states: ALL_RED, HWY_GREEN, HWY_YELLOW, CTY_GREEN, CTY_YELLOW.
- Transitions (evaluated at the rising edge):
  - ALL_RED: if expired & reqH → HWY_GREEN, load MIN_GREEN. If expired & reqC → CTY_GREEN. Otherwise stay; the timer holds at 0.
  - HWY_GREEN: if expired & ~reqH → HWY_YELLOW, load YELLOW. Otherwise stay; green persists while reqH holds.
  - HWY_YELLOW: if expired → ALL_RED, load ALLRED. Unconditional; a request cannot abort yellow.
  - CTY_GREEN and CTY_YELLOW mirror the highway states.
- Latency:
  - Request to green is 1 edge when ALL_RED has already expired.
  - Request drop to yellow is 1 edge when min green has already expired; otherwise yellow starts on the edge after min green expires.
- Direct green→green and yellow→green transitions are impossible.
- FAULT: once set, stays 1 until RST_N is asserted. FAULT does not otherwise alter sequencing.
- Reset mid-operation: lamps go to all-red immediately and asynchronously, including from yellow or green. After release, at least ALLRED_CYCLES of all-red precede any green.

Decomposition:
- Package traffic_pkg holds:
  - phase_t enum: ALL_RED=0, HWY_GREEN=1, HWY_YELLOW=2, CTY_GREEN=3, CTY_YELLOW=4.
  - lamp_t 3-bit {R,Y,G} with constants LAMP_RED, LAMP_YEL, LAMP_GRN.
  - A function mapping phase_t to the two lamp_t values.
- Sub-module phase_timer: parameterised down-counter with ports CLK, RST_N, load, load_val, expired.
- The FSM and output decode stay in traffic_lamp_driver.

Test Plan (default parameters):
1. Release RST_N with HL=1, CL=0 → both roads red for 2 cycles; HWY_G=1 after the 2nd rising edge; CTY_R stays 1.
2. In HWY_GREEN, drop HL after 1 green cycle:
   - HWY_G holds exactly 4 cycles total, then HWY_Y for exactly 3 cycles.
   - Then all-red for 2 cycles, then CTY_G=1 if CL=1 is held.
3. Full handover HL=1→(HL=0, CL=1) → lamp sequence H:G,G,G,G,Y,Y,Y,R,R then C:G. The two roads never show non-red together (checked by an every-cycle assertion).
4. Both requests 0 after highway green expires → yellow for 3 cycles, then ALL_RED held indefinitely. PHASE=0; lamps all red.
5. HL=CL=1 for 1 cycle during HWY_GREEN past min green:
   - FAULT=1 on the next edge; highway goes to yellow, then all-red.
   - FAULT remains 1 after the inputs return to legal values, until reset.
6. Assert RST_N=0 asynchronously mid HWY_YELLOW (between edges) → HWY_R=CTY_R=1 and FAULT=0 immediately. After release with CL=1, CTY_G=1 after 2 edges.
